// File: rtl/mem_responder_if.sv
// mem_responder_if: groups the cache request ports and the RAM port of
// mem_responder into one bundle.
//
// Handshake: a cache raises its request (iREN, or dREN/dWEN) and holds it,
// together with the address and data, until it sees its wait line low.
// Wait is low for exactly one cycle, and that cycle carries the load data.
// On the RAM side the responder holds ramREN or ramWEN with ramaddr and
// ramstore until ram_rdy is high, which marks the cycle ramload is valid.
//
// Modports:
//   slave  - the responder (mem_responder)
//   master - the environment (caches and RAM model)
interface mem_responder_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_rdy;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_rdy,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_rdy,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: arbitrates icache (read-only) and dcache (read/write)
// requests onto one RAM port. Each completion drops the matching wait line
// for one cycle. A RAM that stalls for RAM_TIMEOUT serve cycles gets a forced
// completion that returns ERR_WORD and sets the sticky mem_err flag.
//
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   bus        mem_responder_if.slave (cache request ports + RAM port)
//   dbg_state  current FSM state (0 IDLE, 1 ISERV, 2 DSERV)
//   icount     completed icache requests (only with MEMRESP_STATS_EN)
//   dcount     completed dcache requests (only with MEMRESP_STATS_EN)
//   mem_err    sticky timeout flag, cleared only by RST
//
// Build option: define MEMRESP_STATS_EN to add the icount/dcount counters.
module mem_responder #(
    parameter int          RAM_TIMEOUT = 64,
    parameter logic [31:0] ERR_WORD    = 32'hBAD0BAD0
) (
    input  logic               CLK,
    input  logic               RST,
    mem_responder_if.slave     bus,
    output logic [1:0]         dbg_state,
`ifdef MEMRESP_STATS_EN
    output logic [31:0]        icount,
    output logic [31:0]        dcount,
`endif
    output logic               mem_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISERV = 2'd1,
        DSERV = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic        wr_q, wr_d;        // latched dcache kind: 1 = write
    logic [31:0] tmo_q, tmo_d;      // serve cycles spent without ram_rdy
    logic        last_d_q, last_d_d; // last completed grant went to dcache
    logic        err_q, err_d;
`ifdef MEMRESP_STATS_EN
    logic [31:0] icount_q, icount_d;
    logic [31:0] dcount_q, dcount_d;
`endif

    logic serving;
    logic d_req;
    logic timeout;
    logic done;
    logic still_req;

    assign serving   = (state_q != IDLE);
    assign d_req     = bus.dREN | bus.dWEN;
    assign timeout   = serving && !bus.ram_rdy && (tmo_q == 32'(RAM_TIMEOUT - 1));
    // A completion (real or forced) wins over a request drop in the same cycle.
    assign done      = serving && (bus.ram_rdy || timeout);
    assign still_req = (state_q == ISERV) ? bus.iREN : d_req;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        store_d  = store_q;
        wr_d     = wr_q;
        tmo_d    = tmo_q;
        last_d_d = last_d_q;
        err_d    = err_q;
`ifdef MEMRESP_STATS_EN
        icount_d = icount_q;
        dcount_d = dcount_q;
`endif
        case (state_q)
            IDLE: begin
                // dcache wins a tie unless it also took the previous grant.
                if (d_req && (!bus.iREN || !last_d_q)) begin
                    state_d = DSERV;
                    addr_d  = bus.daddr;
                    store_d = bus.dstore;
                    wr_d    = bus.dWEN;
                    tmo_d   = '0;
                end else if (bus.iREN) begin
                    state_d = ISERV;
                    addr_d  = bus.iaddr;
                    store_d = '0;
                    wr_d    = 1'b0;
                    tmo_d   = '0;
                end
            end
            default: begin
                if (done) begin
                    state_d  = IDLE;
                    last_d_d = (state_q == DSERV);
                    if (timeout) err_d = 1'b1;
`ifdef MEMRESP_STATS_EN
                    if (state_q == ISERV) icount_d = icount_q + 32'd1;
                    else                  dcount_d = dcount_q + 32'd1;
`endif
                end else if (!still_req) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
            tmo_q    <= '0;
            last_d_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef MEMRESP_STATS_EN
            icount_q <= '0;
            dcount_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            wr_q     <= wr_d;
            tmo_q    <= tmo_d;
            last_d_q <= last_d_d;
            err_q    <= err_d;
`ifdef MEMRESP_STATS_EN
            icount_q <= icount_d;
            dcount_q <= dcount_d;
`endif
        end
    end

    // Completion outputs must fall in the same cycle as ram_rdy, so they are
    // decoded from registered state plus the live ram_rdy.
    assign bus.iwait = !(done && (state_q == ISERV));
    assign bus.dwait = !(done && (state_q == DSERV));
    assign bus.iload = (done && (state_q == ISERV))
                       ? (timeout ? ERR_WORD : bus.ramload) : 32'd0;
    // A write completion carries no load value, even when forced.
    assign bus.dload = (done && (state_q == DSERV) && !wr_q)
                       ? (timeout ? ERR_WORD : bus.ramload) : 32'd0;

    assign bus.ramREN   = serving && !wr_q;
    assign bus.ramWEN   = serving && wr_q;
    assign bus.ramaddr  = serving ? addr_q  : 32'd0;
    assign bus.ramstore = serving ? store_q : 32'd0;

    assign dbg_state = state_q;
    assign mem_err   = err_q;
`ifdef MEMRESP_STATS_EN
    assign icount = icount_q;
    assign dcount = dcount_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
    localparam logic [31:0] ERR = 32'hBAD0BAD0;
    localparam logic [1:0] S_IDLE = 2'd0, S_ISERV = 2'd1, S_DSERV = 2'd2;

    logic CLK;
    logic RST;
    logic [1:0] dbg_state;
    logic mem_err;
`ifdef MEMRESP_STATS_EN
    logic [31:0] icount, dcount;
`endif

    mem_responder_if bus ();

    mem_responder #(.RAM_TIMEOUT(4), .ERR_WORD(ERR)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus),
        .dbg_state(dbg_state),
`ifdef MEMRESP_STATS_EN
        .icount(icount),
        .dcount(dcount),
`endif
        .mem_err(mem_err)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- scoreboard ----------------
    // Entry: {is_dcache, load value}
    logic [32:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected entry per completion seen on either wait line.
    always @(negedge CLK) begin
        logic [32:0] got;
        logic [32:0] e;
        if (!RST) begin
            chk("iload_zero_when_waiting", (bus.iwait && bus.iload != 0) ? 64'd1 : 64'd0, 64'd0);
            chk("dload_zero_when_waiting", (bus.dwait && bus.dload != 0) ? 64'd1 : 64'd0, 64'd0);
            if (!bus.iwait && !bus.dwait) begin
                checks++;
                failures++;
                $display("FAIL both_waits_low: got both low expected at most one at %0t", $time);
            end else if (!bus.iwait || !bus.dwait) begin
                got = {!bus.dwait, bus.dwait ? bus.iload : bus.dload};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_completion: got 0x%0h expected none at %0t", got, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("completion", 64'(got), 64'(e));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ram_rdy = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST = 1'b1;
        idle_inputs();
        tick(); tick();
        RST = 1'b0;
        settle();
        chk("rst_state", dbg_state, S_IDLE);
        chk("rst_iwait", bus.iwait, 1);
        chk("rst_dwait", bus.dwait, 1);
        chk("rst_iload", bus.iload, 0);
        chk("rst_dload", bus.dload, 0);
        chk("rst_ramREN", bus.ramREN, 0);
        chk("rst_ramWEN", bus.ramWEN, 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_ramstore", bus.ramstore, 0);
        chk("rst_mem_err", mem_err, 0);
`ifdef MEMRESP_STATS_EN
        chk("rst_icount", icount, 0);
        chk("rst_dcount", dcount, 0);
`endif

        // Icache read, ram_rdy in the second serve cycle
        tick();
        bus.iREN = 1; bus.iaddr = 32'h40;
        exp_q.push_back({1'b0, 32'h8C010004});
        settle();
        chk("ird_c0_state", dbg_state, S_IDLE);
        chk("ird_c0_ramREN", bus.ramREN, 0);
        tick(); settle();
        chk("ird_c1_state", dbg_state, S_ISERV);
        chk("ird_c1_ramREN", bus.ramREN, 1);
        chk("ird_c1_ramWEN", bus.ramWEN, 0);
        chk("ird_c1_ramaddr", bus.ramaddr, 32'h40);
        chk("ird_c1_iwait", bus.iwait, 1);
        tick();
        bus.ram_rdy = 1; bus.ramload = 32'h8C010004;
        settle();
        chk("ird_c2_iwait", bus.iwait, 0);
        chk("ird_c2_iload", bus.iload, 32'h8C010004);
        tick();
        idle_inputs();
        settle();
        chk("ird_c3_state", dbg_state, S_IDLE);
        chk("ird_c3_iwait", bus.iwait, 1);
        chk("ird_c3_ramREN", bus.ramREN, 0);
`ifdef MEMRESP_STATS_EN
        chk("ird_icount", icount, 1);
`endif

        // Dcache write with dREN also high: write dominates
        tick();
        bus.dWEN = 1; bus.dREN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF; bus.ram_rdy = 1;
        exp_q.push_back({1'b1, 32'h0});
        settle();
        chk("dwr_c0_state", dbg_state, S_IDLE);
        tick(); settle();
        chk("dwr_c1_state", dbg_state, S_DSERV);
        chk("dwr_c1_ramWEN", bus.ramWEN, 1);
        chk("dwr_c1_ramREN", bus.ramREN, 0);
        chk("dwr_c1_ramaddr", bus.ramaddr, 32'h100);
        chk("dwr_c1_ramstore", bus.ramstore, 32'hDEADBEEF);
        chk("dwr_c1_dwait", bus.dwait, 0);
        tick();
        idle_inputs();
        settle();
        chk("dwr_c2_state", dbg_state, S_IDLE);
        chk("dwr_c2_dwait", bus.dwait, 1);
`ifdef MEMRESP_STATS_EN
        chk("dwr_dcount", dcount, 1);
`endif

        // Contention after reset: grants D, I, D, I with a bubble between each
        tick(); RST = 1;
        tick(); RST = 0;
        bus.iREN = 1; bus.dREN = 1; bus.iaddr = 32'h500; bus.daddr = 32'h600;
        bus.ram_rdy = 1; bus.ramload = 32'hA0000000;
        settle();
        chk("arb_k0_state", dbg_state, S_IDLE);
        for (int k = 1; k < 8; k++) begin
            tick();
            bus.ramload = 32'hA0000000 + 32'(k);
            if (k % 4 == 1) exp_q.push_back({1'b1, 32'hA0000000 + 32'(k)});
            if (k % 4 == 3) exp_q.push_back({1'b0, 32'hA0000000 + 32'(k)});
            settle();
            if (k % 2 == 0) chk("arb_state_idle", dbg_state, S_IDLE);
            else if (k % 4 == 1) chk("arb_state_d", dbg_state, S_DSERV);
            else chk("arb_state_i", dbg_state, S_ISERV);
        end
        tick();
        idle_inputs();
        settle();
        chk("arb_end_state", dbg_state, S_IDLE);
`ifdef MEMRESP_STATS_EN
        chk("arb_icount", icount, 2);
        chk("arb_dcount", dcount, 2);
`endif

        // Icache timeout: forced completion in the 4th serve cycle
        tick();
        bus.iREN = 1; bus.iaddr = 32'h80;
        settle();
        for (int s = 1; s <= 4; s++) begin
            tick();
            if (s == 4) exp_q.push_back({1'b0, ERR});
            settle();
            chk("itmo_iwait", bus.iwait, (s == 4) ? 1'b0 : 1'b1);
            chk("itmo_mem_err_pre", mem_err, 0);
        end
        tick();
        bus.iREN = 0;
        settle();
        chk("itmo_mem_err_set", mem_err, 1);
        chk("itmo_state", dbg_state, S_IDLE);

        // Dcache write timeout: no load value, mem_err stays set
        tick();
        bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'h12345678;
        settle();
        for (int s = 1; s <= 4; s++) begin
            tick();
            if (s == 4) exp_q.push_back({1'b1, 32'h0});
            settle();
            chk("dtmo_dwait", bus.dwait, (s == 4) ? 1'b0 : 1'b1);
            chk("dtmo_mem_err", mem_err, 1);
        end
        tick();
        bus.dWEN = 0;
        settle();
        chk("dtmo_state", dbg_state, S_IDLE);
`ifdef MEMRESP_STATS_EN
        chk("tmo_icount", icount, 3);
        chk("tmo_dcount", dcount, 3);
`endif

        // Tie after a dcache grant goes to icache; then abort it
        tick();
        bus.iREN = 1; bus.dREN = 1; bus.iaddr = 32'h44; bus.daddr = 32'h88;
        settle();
        tick(); settle();
        chk("tie_after_d_state", dbg_state, S_ISERV);
        chk("abort_c1_ramaddr", bus.ramaddr, 32'h44);
        tick(); settle();
        chk("abort_c2_state", dbg_state, S_ISERV);
        tick();
        bus.iREN = 0; bus.dREN = 0;
        settle();
        chk("abort_c3_iwait", bus.iwait, 1);
        tick(); settle();
        chk("abort_c4_state", dbg_state, S_IDLE);
        chk("abort_c4_ramREN", bus.ramREN, 0);
        chk("abort_c4_iwait", bus.iwait, 1);
        chk("abort_mem_err", mem_err, 1);
`ifdef MEMRESP_STATS_EN
        chk("abort_icount", icount, 3);
`endif

        // Reset in the middle of a dcache write
        tick();
        bus.dWEN = 1; bus.daddr = 32'h300; bus.dstore = 32'hCAFEF00D;
        settle();
        tick(); settle();
        chk("rstm_state_pre", dbg_state, S_DSERV);
        chk("rstm_ramWEN_pre", bus.ramWEN, 1);
        tick();
        RST = 1;
        settle();
        tick();
        RST = 0; bus.dWEN = 0;
        settle();
        chk("rstm_state", dbg_state, S_IDLE);
        chk("rstm_dwait", bus.dwait, 1);
        chk("rstm_ramWEN", bus.ramWEN, 0);
        chk("rstm_ramREN", bus.ramREN, 0);
        chk("rstm_ramaddr", bus.ramaddr, 0);
        chk("rstm_mem_err", mem_err, 0);
`ifdef MEMRESP_STATS_EN
        chk("rstm_icount", icount, 0);
        chk("rstm_dcount", dcount, 0);
`endif

        tick(); tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 0);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the instruction and data cache request ports. It accepts level-held requests from the icache (read-only) and dcache (read/write) and arbitrates them onto a single RAM port. It returns each completion with a one-cycle wait-release, and guards against a stalled RAM with a timeout. It sits between the caches and the RAM model, at the memory end of the cache request interface.

## Interface
Parameters:
- RAM_TIMEOUT, default 64: cycles a serve state may wait for ram_rdy before forced completion.
- ERR_WORD, default 32'hBAD0BAD0: load value returned on timeout.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  icache read request, level, held until iwait low.
- iaddr  in  32  icache word address.
- iwait  out  1  low for exactly one cycle when iload is valid.
- iload  out  32  instruction word.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; wins over dREN if both are high.
- daddr  in  32  dcache address.
- dstore  in  32  dcache write data.
- dwait  out  1  low for exactly one cycle on completion.
- dload  out  32  dcache read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, valid when ram_rdy is high.
- ram_rdy  in  1  RAM access complete this cycle.
- mem_err  out  1  sticky timeout flag.
- icount, dcount  out  32 each  completed-request counters; present only with MEMRESP_STATS_EN.

## Operation
States:
- IDLE: no RAM access.
- ISERV: serving the icache.
- DSERV: serving the dcache.

Arbitration in IDLE:
- Only one requester active: it is granted. iREN selects ISERV; dREN or dWEN selects DSERV.
- Both active: dcache wins, unless the last completed grant was the dcache. In that case the icache wins.
- The last-grant flag resets to "icache", so after reset dcache wins.

Entering a serve state:
- Latch the request address. For a dcache request, also latch dstore and the read/write kind (dWEN dominates).
- Clear the timeout counter.

In a serve state:
- Drive ramaddr and ramstore from the latched values.
- Drive ramREN or ramWEN from the latched kind. Exactly one enable is high.
- Enables are 0 in IDLE.

Completion:
- ram_rdy high in a serve state: the matching wait goes low that same cycle.
- The load output for a read equals ramload.
- Next state is IDLE, which leaves one bubble cycle between grants.
- The last-grant flag and the counter (if enabled) update on completion.

Timeout:
- The counter increments each serve cycle in which ram_rdy is low.
- When the counter equals RAM_TIMEOUT-1 and ram_rdy is still low, that cycle is a forced completion: wait goes low, load = ERR_WORD, mem_err is set, and the next state is IDLE.
- A write completed by timeout drives no load value.

Abort:
- If the served requester drops its request while in a serve state, the block returns to IDLE next cycle without asserting wait. No counter update occurs.

Output rules:
- iload and dload are 0 whenever their wait is high.
- Waits are high in every cycle except a completion cycle.

## Timing
Reset values:
- state IDLE, iwait=1, dwait=1, iload=0, dload=0.
- ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- mem_err=0, counters 0.
- Latch and timeout counter cleared.

Latency:
- Request seen in IDLE at cycle 0; serve state at cycle 1; RAM enables high from cycle 1.
- Earliest completion is cycle 1 (ram_rdy high in cycle 1).
- Back-to-back requests from one requester have a throughput of one per 2 cycles minimum.

Edge and simultaneous cases:
- Completion and request drop in the same cycle: counts as completion.
- Reset in the middle of a serve: all outputs return to reset values next cycle, and mem_err clears.
- mem_err clears only on RST.
- Counters wrap modulo 2^32.

## Configuration
- MEMRESP_STATS_EN defined: icount and dcount ports and counters exist. Each increments by 1 on a completion for its requester, including timeout completions.
- MEMRESP_STATS_EN undefined: the ports and counter registers are absent, and behaviour is otherwise identical.

## Test plan
- Icache read: iREN=1, iaddr=0x40; ram_rdy high in the second serve cycle with ramload=0x8C010004 -> ramREN=1, ramaddr=0x40; iwait low for one cycle with iload=0x8C010004; state returns to IDLE.
- Dcache write: dWEN=1 and dREN=1 together, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait pulses low once.
- Contention: iREN and dREN held continuously, ram_rdy=1 always -> grants alternate D, I, D, I, with a completion every 2 cycles.
- Timeout: iREN=1, ram_rdy stuck low, RAM_TIMEOUT=4 -> iwait low in the 4th serve cycle, iload=0xBAD0BAD0, mem_err=1 and stays 1 until RST.
- Abort: iREN=1 for 2 serve cycles then dropped with no ram_rdy -> ramREN=0 next cycle, iwait never low, icount unchanged.
- Reset mid-serve: RST=1 during DSERV -> next cycle dwait=1, ramWEN=ramREN=0, counters 0, state IDLE.
